k005292_tile_shifter: RTL and testbench
=======================================

Name: k005292_tile_shifter

Overview:
- Tilemap pixel serializer directly downstream of the K005291 tilemap generator.
- Captures the tile code/attribute words that VRAM returns for the generator's fetch addresses, and captures CHARRAM line data.
- Loads per-layer shift registers on the generator's SHIFTA1/SHIFTA2/SHIFTB strobes.
- Shifts out one 4bpp pixel per 6 MHz pixel enable for layers A and B, each with its latched palette code, toward the priority/palette stage.

Parameters:
- PIX_W, 4, bits per pixel; fixes the CHARRAM line word at 8*PIX_W bits.
- PAL_W, 6, palette code width taken from the tile attribute.

Ports:
- i_EMU_MCLK  in  1  master clock, 36.864 MHz.
- i_EMU_MRST_n  in  1  asynchronous active-low reset.
- i_EMU_CLK6MPCEN_n  in  1  pixel clock enable, active low; all state advances only when low.
- i_ABS_4H, i_ABS_2H, i_ABS_1H  in  1 each  pixel phase within the 8-pixel fetch slot.
- i_VRAMDATA  in  16  VRAM tile word: [10:0] code, [11] hflip, [12] vflip (unused here), [15:13] low palette bits; [PAL_W-1:3] of the palette code come from i_VRAMDATA_HI.
- i_VRAMDATA_HI  in  PAL_W-3  high palette bits from the VRAM2 half.
- i_CHARDATA  in  8*PIX_W  CHARRAM line data; pixel 0 in the MSBs.
- i_SHIFTA1_n, i_SHIFTA2_n, i_SHIFTB_n  in  1 each  load strobes from K005291, active low.
- o_TILECODE  out  11  code presented to the CHARRAM address.
- o_A_PIXEL  out  PIX_W  layer A pixel.
- o_A_PAL  out  PAL_W  layer A palette code.
- o_B_PIXEL  out  PIX_W  layer B pixel.
- o_B_PAL  out  PAL_W  layer B palette code.

Behaviour:
- Advance rule: all registers update on posedge i_EMU_MCLK only when i_EMU_CLK6MPCEN_n=0. Otherwise every register holds.
- Reset: when i_EMU_MRST_n=0, every register clears asynchronously. o_A_PIXEL, o_B_PIXEL, o_A_PAL, o_B_PAL and o_TILECODE all read 0. Pending "valid" flags clear. Release takes effect at the next enabled edge.
- Phase p = {4H,2H,1H}.
- Attribute capture:
  - p=3: latch i_VRAMDATA/i_VRAMDATA_HI into the A attribute latch (code, hflip, palette).
  - p=7: latch them into the B attribute latch.
- o_TILECODE: A latch code while 4H=1, B latch code while 4H=0. This is registered and changes on the edge after capture.
- Char capture, done one full pixel after code presentation:
  - p=5: i_CHARDATA goes to the A pending word; set A_pend_valid.
  - p=1: i_CHARDATA goes to the B pending word; set B_pend_valid.
  - The pending word stores data pre-reversed by pixel when the corresponding hflip=1, so the shifter always shifts MSB-first.
- Layer A shifter:
  - i_SHIFTA1_n=0: load the A pending word into the shifter; clear A_pend_valid.
  - Otherwise shift left by PIX_W, filling with 0.
  - o_A_PIXEL = shifter MSBs, registered, so latency is 1 enable from load to first pixel.
- Layer A palette: i_SHIFTA2_n=0 copies the A latch palette into o_A_PAL. This is an independent strobe, so the palette can change half a tile offset from the pixel data, per fine scroll.
- Layer B: i_SHIFTB_n=0 loads the shifter and o_B_PAL together; it otherwise shifts identically to layer A.
- Load with A_pend_valid=0 (first slot after reset): loads zeros, giving transparent pixels. No error is raised.
- Strobe on consecutive enables: each one reloads the same pending word (already cleared → zeros). The shifter never underflows; after 8 shifts it outputs 0.
- Simultaneous capture and load of the same pending word in one enable: the load takes the OLD pending value and the capture writes the new one. Same-edge read-before-write.
- i_SHIFTA1_n and i_SHIFTA2_n asserted together: both actions occur.
- Reset asserted mid-line: outputs go to 0 immediately. Output resumes cleanly at the first strobe after a complete capture.

Optional Feature:
- Macro: K005292_TILE_SHIFTER_MIX_EN.
- When defined, adds two outputs:
  - o_MIX_PIXEL (PIX_W)
  - o_MIX_PAL (PAL_W)
- Both are registered. Each enable they carry layer A if o_A_PIXEL!=0, else layer B.
- They add one extra enable of latency relative to the per-layer outputs and reset to 0.
- When undefined, these ports and their logic are absent; per-layer behaviour is identical in both builds.

Test Plan:
- Reset release, no strobes → o_A_PIXEL=o_B_PIXEL=0, o_A_PAL=o_B_PAL=0, o_TILECODE=0 for 16 enables.
- VRAM A word 16'h2123 (code 0x123, palette low 1), CHARDATA 32'h12345678, hflip=0, i_SHIFTA1_n low at p=7 → o_A_PIXEL sequence 1,2,3,4,5,6,7,8, then 0.
- Same stimulus with VRAM word 16'h2923 (hflip=1) → o_A_PIXEL sequence 8,7,6,5,4,3,2,1.
- i_SHIFTA2_n pulsed 4 enables after i_SHIFTA1_n, with a new A palette latched in between → o_A_PAL changes exactly on the enable after the SHIFTA2 strobe, not on SHIFTA1.
- Hold i_EMU_CLK6MPCEN_n high for 5 MCLKs mid-tile → outputs frozen, sequence resumes with no pixel lost.
- MIX_EN build, A pixels 0,3,0 with B pixels 5,5,5 → o_MIX_PIXEL 5,3,5, one enable after the per-layer outputs.

Source files
------------

// File: rtl/k005292_tile_shifter_if.sv
`default_nettype none
// ============================================================================
// Module   : k005292_tile_shifter_if
// Purpose  : Bundles the pixel-phase, VRAM/CHARRAM data, load strobes and
//            pixel/palette outputs of the K005292 tile shifter.
//            The MIX outputs exist only when K005292_TILE_SHIFTER_MIX_EN
//            is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface k005292_tile_shifter_if #(
  parameter int PIX_W = 4,
  parameter int PAL_W = 6
);
  logic                  i_EMU_CLK6MPCEN_n;
  logic                  i_ABS_4H;
  logic                  i_ABS_2H;
  logic                  i_ABS_1H;
  logic [15:0]           i_VRAMDATA;
  logic [PAL_W-4:0]      i_VRAMDATA_HI;
  logic [8*PIX_W-1:0]    i_CHARDATA;
  logic                  i_SHIFTA1_n;
  logic                  i_SHIFTA2_n;
  logic                  i_SHIFTB_n;
  logic [10:0]           o_TILECODE;
  logic [PIX_W-1:0]      o_A_PIXEL;
  logic [PAL_W-1:0]      o_A_PAL;
  logic [PIX_W-1:0]      o_B_PIXEL;
  logic [PAL_W-1:0]      o_B_PAL;
`ifdef K005292_TILE_SHIFTER_MIX_EN
  logic [PIX_W-1:0]      o_MIX_PIXEL;
  logic [PAL_W-1:0]      o_MIX_PAL;

  modport master (
    output i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H,
    output i_VRAMDATA, i_VRAMDATA_HI, i_CHARDATA,
    output i_SHIFTA1_n, i_SHIFTA2_n, i_SHIFTB_n,
    input  o_TILECODE, o_A_PIXEL, o_A_PAL, o_B_PIXEL, o_B_PAL,
    input  o_MIX_PIXEL, o_MIX_PAL
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H,
    input  i_VRAMDATA, i_VRAMDATA_HI, i_CHARDATA,
    input  i_SHIFTA1_n, i_SHIFTA2_n, i_SHIFTB_n,
    output o_TILECODE, o_A_PIXEL, o_A_PAL, o_B_PIXEL, o_B_PAL,
    output o_MIX_PIXEL, o_MIX_PAL
  );
`else
  modport master (
    output i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H,
    output i_VRAMDATA, i_VRAMDATA_HI, i_CHARDATA,
    output i_SHIFTA1_n, i_SHIFTA2_n, i_SHIFTB_n,
    input  o_TILECODE, o_A_PIXEL, o_A_PAL, o_B_PIXEL, o_B_PAL
  );

  modport slave (
    input  i_EMU_CLK6MPCEN_n, i_ABS_4H, i_ABS_2H, i_ABS_1H,
    input  i_VRAMDATA, i_VRAMDATA_HI, i_CHARDATA,
    input  i_SHIFTA1_n, i_SHIFTA2_n, i_SHIFTB_n,
    output o_TILECODE, o_A_PIXEL, o_A_PAL, o_B_PIXEL, o_B_PAL
  );
`endif
endinterface
`default_nettype wire

// File: rtl/k005292_tile_shifter.sv
`default_nettype none
// ============================================================================
// Module   : k005292_tile_shifter
// Purpose  : Tilemap pixel serializer behind the K005291. Captures tile
//            attributes and CHARRAM line words per 8-pixel slot, loads the
//            layer A/B shifters on the generator strobes and emits one
//            pixel per 6 MHz enable per layer with its palette code.
//            Optional A-over-B mix outputs: K005292_TILE_SHIFTER_MIX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module k005292_tile_shifter #(
  parameter int PIX_W = 4,
  parameter int PAL_W = 6
) (
  input  wire                    i_EMU_MCLK,
  input  wire                    i_EMU_MRST_n,
  k005292_tile_shifter_if.slave  bus
);

  localparam int c_WORD_W = 8 * PIX_W;

  logic [2:0]          w_phase;
  logic                w_en;
  logic [c_WORD_W-1:0] w_char_rev;
  logic [PAL_W-1:0]    w_vram_pal;
  logic                w_unused_vflip;

  // Attribute latches
  logic [10:0]         a_code_q, a_code_d, b_code_q, b_code_d;
  logic                a_hflip_q, a_hflip_d, b_hflip_q, b_hflip_d;
  logic [PAL_W-1:0]    a_pal_q, a_pal_d, b_pal_q, b_pal_d;
  logic [10:0]         tilecode_q, tilecode_d;
  // Pending CHARRAM words (already pixel-reversed for hflip)
  logic [c_WORD_W-1:0] a_pend_q, a_pend_d, b_pend_q, b_pend_d;
  logic                a_pend_v_q, a_pend_v_d, b_pend_v_q, b_pend_v_d;
  // Shifters and registered outputs
  logic [c_WORD_W-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [PIX_W-1:0]    a_pix_q, a_pix_d, b_pix_q, b_pix_d;
  logic [PAL_W-1:0]    a_opal_q, a_opal_d, b_opal_q, b_opal_d;

  assign w_phase        = {bus.i_ABS_4H, bus.i_ABS_2H, bus.i_ABS_1H};
  assign w_en           = ~bus.i_EMU_CLK6MPCEN_n;
  assign w_vram_pal     = {bus.i_VRAMDATA_HI, bus.i_VRAMDATA[15:13]};
  // vflip is resolved upstream in the CHARRAM row address
  assign w_unused_vflip = bus.i_VRAMDATA[12];

  // Pixel-order reversal of the CHARRAM word for horizontally flipped tiles
  for (genvar gi = 0; gi < 8; gi++) begin : g_rev
    assign w_char_rev[gi*PIX_W +: PIX_W] = bus.i_CHARDATA[(7-gi)*PIX_W +: PIX_W];
  end

  // Next-state: attribute/char capture by phase, strobe loads, shifting
  always_comb begin
    a_code_d   = a_code_q;
    a_hflip_d  = a_hflip_q;
    a_pal_d    = a_pal_q;
    b_code_d   = b_code_q;
    b_hflip_d  = b_hflip_q;
    b_pal_d    = b_pal_q;
    a_pend_d   = a_pend_q;
    a_pend_v_d = a_pend_v_q;
    b_pend_d   = b_pend_q;
    b_pend_v_d = b_pend_v_q;
    a_opal_d   = a_opal_q;
    b_opal_d   = b_opal_q;

    // Code for the CHARRAM address follows the 4H half of the slot
    tilecode_d = bus.i_ABS_4H ? a_code_q : b_code_q;

    // Pixel outputs are the shifter MSBs, one enable behind the shifter
    a_pix_d = a_sh_q[c_WORD_W-1 -: PIX_W];
    b_pix_d = b_sh_q[c_WORD_W-1 -: PIX_W];

    // Loads read the pending word before any capture on the same edge
    if (!bus.i_SHIFTA1_n) begin
      a_sh_d     = a_pend_v_q ? a_pend_q : '0;
      a_pend_v_d = 1'b0;
    end else begin
      a_sh_d = a_sh_q << PIX_W;
    end
    if (!bus.i_SHIFTA2_n) begin
      a_opal_d = a_pal_q;
    end
    if (!bus.i_SHIFTB_n) begin
      b_sh_d     = b_pend_v_q ? b_pend_q : '0;
      b_pend_v_d = 1'b0;
      b_opal_d   = b_pal_q;
    end else begin
      b_sh_d = b_sh_q << PIX_W;
    end

    // Capture wins over a same-edge load clearing the valid flag
    if (w_phase == 3'd5) begin
      a_pend_d   = a_hflip_q ? w_char_rev : bus.i_CHARDATA;
      a_pend_v_d = 1'b1;
    end
    if (w_phase == 3'd1) begin
      b_pend_d   = b_hflip_q ? w_char_rev : bus.i_CHARDATA;
      b_pend_v_d = 1'b1;
    end

    if (w_phase == 3'd3) begin
      a_code_d  = bus.i_VRAMDATA[10:0];
      a_hflip_d = bus.i_VRAMDATA[11];
      a_pal_d   = w_vram_pal;
    end
    if (w_phase == 3'd7) begin
      b_code_d  = bus.i_VRAMDATA[10:0];
      b_hflip_d = bus.i_VRAMDATA[11];
      b_pal_d   = w_vram_pal;
    end
  end

  // State register: advances only on enabled pixel edges
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      a_code_q   <= '0;
      a_hflip_q  <= 1'b0;
      a_pal_q    <= '0;
      b_code_q   <= '0;
      b_hflip_q  <= 1'b0;
      b_pal_q    <= '0;
      tilecode_q <= '0;
      a_pend_q   <= '0;
      a_pend_v_q <= 1'b0;
      b_pend_q   <= '0;
      b_pend_v_q <= 1'b0;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      a_pix_q    <= '0;
      b_pix_q    <= '0;
      a_opal_q   <= '0;
      b_opal_q   <= '0;
    end else if (w_en) begin
      a_code_q   <= a_code_d;
      a_hflip_q  <= a_hflip_d;
      a_pal_q    <= a_pal_d;
      b_code_q   <= b_code_d;
      b_hflip_q  <= b_hflip_d;
      b_pal_q    <= b_pal_d;
      tilecode_q <= tilecode_d;
      a_pend_q   <= a_pend_d;
      a_pend_v_q <= a_pend_v_d;
      b_pend_q   <= b_pend_d;
      b_pend_v_q <= b_pend_v_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      a_pix_q    <= a_pix_d;
      b_pix_q    <= b_pix_d;
      a_opal_q   <= a_opal_d;
      b_opal_q   <= b_opal_d;
    end
  end

  assign bus.o_TILECODE = tilecode_q;
  assign bus.o_A_PIXEL  = a_pix_q;
  assign bus.o_A_PAL    = a_opal_q;
  assign bus.o_B_PIXEL  = b_pix_q;
  assign bus.o_B_PAL    = b_opal_q;

`ifdef K005292_TILE_SHIFTER_MIX_EN
  logic [PIX_W-1:0] mix_pix_q, mix_pix_d;
  logic [PAL_W-1:0] mix_pal_q, mix_pal_d;

  // Layer A wins wherever its pixel is opaque
  always_comb begin
    mix_pix_d = (a_pix_q != '0) ? a_pix_q  : b_pix_q;
    mix_pal_d = (a_pix_q != '0) ? a_opal_q : b_opal_q;
  end

  // Mix register adds one enable of latency behind the layer outputs
  always_ff @(posedge i_EMU_MCLK or negedge i_EMU_MRST_n) begin
    if (!i_EMU_MRST_n) begin
      mix_pix_q <= '0;
      mix_pal_q <= '0;
    end else if (w_en) begin
      mix_pix_q <= mix_pix_d;
      mix_pal_q <= mix_pal_d;
    end
  end

  assign bus.o_MIX_PIXEL = mix_pix_q;
  assign bus.o_MIX_PAL   = mix_pal_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_k005292_tile_shifter.sv
`default_nettype none
// ============================================================================
// Module   : tb_k005292_tile_shifter
// Purpose  : Self-checking bench for k005292_tile_shifter: directed scenarios
//            plus randomized traffic against a pixel-queue reference model.
//            Mix checks are compiled with K005292_TILE_SHIFTER_MIX_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_k005292_tile_shifter;

  localparam int PIX_W    = 4;
  localparam int PAL_W    = 6;
  localparam int c_WORD_W = 8 * PIX_W;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  k005292_tile_shifter_if #(.PIX_W(PIX_W), .PAL_W(PAL_W)) bus ();

  k005292_tile_shifter #(.PIX_W(PIX_W), .PAL_W(PAL_W)) dut (
    .i_EMU_MCLK   (clk),
    .i_EMU_MRST_n (rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (pixel lists, not registers) ----------
  logic [2:0]       m_p;
  logic [10:0]      m_a_code, m_b_code, m_tile;
  logic             m_a_hflip, m_b_hflip;
  logic [PAL_W-1:0] m_a_pal, m_b_pal, m_a_opal, m_b_opal, m_mix_pal;
  logic [PIX_W-1:0] m_a_pend[8], m_b_pend[8];
  bit               m_a_valid, m_b_valid;
  logic [PIX_W-1:0] m_a_q[$], m_b_q[$];
  logic [PIX_W-1:0] m_a_pix, m_b_pix, m_mix_pix;

  task automatic model_reset();
    m_p = 3'd0; m_a_code = '0; m_b_code = '0; m_tile = '0;
    m_a_hflip = 1'b0; m_b_hflip = 1'b0;
    m_a_pal = '0; m_b_pal = '0; m_a_opal = '0; m_b_opal = '0; m_mix_pal = '0;
    for (int i = 0; i < 8; i++) begin m_a_pend[i] = '0; m_b_pend[i] = '0; end
    m_a_valid = 1'b0; m_b_valid = 1'b0;
    m_a_q.delete(); m_b_q.delete();
    m_a_pix = '0; m_b_pix = '0; m_mix_pix = '0;
  endtask

  // One enabled pixel step, using the inputs that were present at the edge
  task automatic model_step();
    logic [10:0]         tile_n;
    logic [PIX_W-1:0]    cd[8];
    logic [c_WORD_W-1:0] chr;
    logic [PAL_W-1:0]    vpal;
    chr    = bus.i_CHARDATA;
    vpal   = {bus.i_VRAMDATA_HI, bus.i_VRAMDATA[15:13]};
    tile_n = m_p[2] ? m_a_code : m_b_code;
    for (int i = 0; i < 8; i++) cd[i] = chr[(7-i)*PIX_W +: PIX_W];

    m_mix_pix = (m_a_pix != 0) ? m_a_pix : m_b_pix;
    m_mix_pal = (m_a_pix != 0) ? m_a_opal : m_b_opal;
    m_a_pix = (m_a_q.size() > 0) ? m_a_q[0] : '0;
    m_b_pix = (m_b_q.size() > 0) ? m_b_q[0] : '0;

    if (!bus.i_SHIFTA1_n) begin
      m_a_q.delete();
      for (int i = 0; i < 8; i++) m_a_q.push_back(m_a_valid ? m_a_pend[i] : '0);
      m_a_valid = 1'b0;
    end else if (m_a_q.size() > 0) begin
      void'(m_a_q.pop_front());
    end
    if (!bus.i_SHIFTA2_n) m_a_opal = m_a_pal;
    if (!bus.i_SHIFTB_n) begin
      m_b_q.delete();
      for (int i = 0; i < 8; i++) m_b_q.push_back(m_b_valid ? m_b_pend[i] : '0);
      m_b_valid = 1'b0;
      m_b_opal  = m_b_pal;
    end else if (m_b_q.size() > 0) begin
      void'(m_b_q.pop_front());
    end

    if (m_p == 3'd5) begin
      for (int i = 0; i < 8; i++) m_a_pend[i] = m_a_hflip ? cd[7-i] : cd[i];
      m_a_valid = 1'b1;
    end
    if (m_p == 3'd1) begin
      for (int i = 0; i < 8; i++) m_b_pend[i] = m_b_hflip ? cd[7-i] : cd[i];
      m_b_valid = 1'b1;
    end
    if (m_p == 3'd3) begin
      m_a_code = bus.i_VRAMDATA[10:0]; m_a_hflip = bus.i_VRAMDATA[11]; m_a_pal = vpal;
    end
    if (m_p == 3'd7) begin
      m_b_code = bus.i_VRAMDATA[10:0]; m_b_hflip = bus.i_VRAMDATA[11]; m_b_pal = vpal;
    end
    m_tile = tile_n;
  endtask

  // ---------------- stimulus helpers --------------------------------------
  task automatic set_idle();
    bus.i_SHIFTA1_n = 1'b1;
    bus.i_SHIFTA2_n = 1'b1;
    bus.i_SHIFTB_n  = 1'b1;
  endtask

  // Drive phase/enable, take one MCLK edge, sample 1 ns later
  task automatic step(input bit en);
    bus.i_ABS_4H          = m_p[2];
    bus.i_ABS_2H          = m_p[1];
    bus.i_ABS_1H          = m_p[0];
    bus.i_EMU_CLK6MPCEN_n = ~en;
    @(posedge clk);
    #1;
    if (en && rst_n) begin
      model_step();
      m_p = m_p + 3'd1;
    end
  endtask

  task automatic do_reset();
    set_idle();
    bus.i_VRAMDATA = '0; bus.i_VRAMDATA_HI = '0; bus.i_CHARDATA = '0;
    rst_n = 1'b0;
    step(1'b1);
    step(1'b1);
    model_reset();
    rst_n = 1'b1;
  endtask

  // One slot with A word captured and SHIFTA1 low at p=7
  task automatic load_a_slot(input logic [15:0] vram, input logic [31:0] chr);
    bus.i_VRAMDATA = vram; bus.i_VRAMDATA_HI = '0; bus.i_CHARDATA = chr;
    for (int k = 0; k < 8; k++) begin
      bus.i_SHIFTA1_n = (m_p == 3'd7) ? 1'b0 : 1'b1;
      step(1'b1);
    end
    set_idle();
  endtask

  // ---------------- tests --------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 16; k++) begin
      step(1'b1);
      n_vec += 5;
      if (bus.o_A_PIXEL !== '0) begin n_err++; $display("FAIL reset_a_pix k=%0d got %h want 0", k, bus.o_A_PIXEL); end
      if (bus.o_B_PIXEL !== '0) begin n_err++; $display("FAIL reset_b_pix k=%0d got %h want 0", k, bus.o_B_PIXEL); end
      if (bus.o_A_PAL !== '0)   begin n_err++; $display("FAIL reset_a_pal k=%0d got %h want 0", k, bus.o_A_PAL); end
      if (bus.o_B_PAL !== '0)   begin n_err++; $display("FAIL reset_b_pal k=%0d got %h want 0", k, bus.o_B_PAL); end
      if (bus.o_TILECODE !== '0) begin n_err++; $display("FAIL reset_tile k=%0d got %h want 0", k, bus.o_TILECODE); end
    end
  endtask

  task automatic test_shift(input bit hflip);
    logic [PIX_W-1:0] exp;
    do_reset();
    bus.i_VRAMDATA = hflip ? 16'h2923 : 16'h2123; bus.i_VRAMDATA_HI = '0;
    bus.i_CHARDATA = 32'h12345678;
    for (int k = 0; k < 8; k++) begin
      bus.i_SHIFTA1_n = (m_p == 3'd7) ? 1'b0 : 1'b1;
      step(1'b1);
      if (m_p == 3'd5) begin
        n_vec++;
        if (bus.o_TILECODE !== 11'h123) begin n_err++; $display("FAIL tilecode got %h want 123", bus.o_TILECODE); end
      end
    end
    set_idle();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1);
      exp = (k > 8) ? 4'd0 : (hflip ? 4'(9 - k) : 4'(k));
      n_vec++;
      if (bus.o_A_PIXEL !== exp) begin n_err++; $display("FAIL shift_hflip%0d k=%0d got %h want %h", hflip, k, bus.o_A_PIXEL, exp); end
    end
  endtask

  task automatic test_pal_split();
    logic [PAL_W-1:0] p1, p2;
    p1 = 6'h11; p2 = 6'h2E;
    do_reset();
    bus.i_CHARDATA = 32'h12345678;
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < 8; k++) begin
        bus.i_VRAMDATA    = (s == 0) ? 16'h2123 : 16'hC123;
        bus.i_VRAMDATA_HI = (s == 0) ? 3'b010 : 3'b101;
        bus.i_SHIFTA2_n   = ((s == 0 && m_p == 3'd7) || (s == 1 && m_p == 3'd5)) ? 1'b0 : 1'b1;
        bus.i_SHIFTA1_n   = (s == 1 && m_p == 3'd1) ? 1'b0 : 1'b1;
        step(1'b1);
        if (s == 1 && k >= 1 && k <= 5) begin
          n_vec++;
          if (bus.o_A_PAL !== ((k == 5) ? p2 : p1)) begin
            n_err++; $display("FAIL pal_split k=%0d got %h want %h", k, bus.o_A_PAL, (k == 5) ? p2 : p1);
          end
        end
      end
    end
    set_idle();
  endtask

  task automatic test_enable_hold();
    do_reset();
    load_a_slot(16'h2123, 32'h12345678);
    for (int k = 1; k <= 3; k++) begin
      step(1'b1);
      n_vec++;
      if (bus.o_A_PIXEL !== 4'(k)) begin n_err++; $display("FAIL hold_pre k=%0d got %h want %h", k, bus.o_A_PIXEL, 4'(k)); end
    end
    for (int k = 0; k < 5; k++) begin
      step(1'b0);
      n_vec++;
      if (bus.o_A_PIXEL !== 4'd3) begin n_err++; $display("FAIL hold_frozen k=%0d got %h want 3", k, bus.o_A_PIXEL); end
    end
    for (int k = 4; k <= 8; k++) begin
      step(1'b1);
      n_vec++;
      if (bus.o_A_PIXEL !== 4'(k)) begin n_err++; $display("FAIL hold_post k=%0d got %h want %h", k, bus.o_A_PIXEL, 4'(k)); end
    end
  endtask

  task automatic test_reset_midline();
    do_reset();
    load_a_slot(16'h2123, 32'h12345678);
    for (int k = 0; k < 3; k++) step(1'b1);
    rst_n = 1'b0;
    #2;
    n_vec += 3;
    if (bus.o_A_PIXEL !== '0)  begin n_err++; $display("FAIL midrst_a_pix got %h want 0", bus.o_A_PIXEL); end
    if (bus.o_A_PAL !== '0)    begin n_err++; $display("FAIL midrst_a_pal got %h want 0", bus.o_A_PAL); end
    if (bus.o_TILECODE !== '0) begin n_err++; $display("FAIL midrst_tile got %h want 0", bus.o_TILECODE); end
    @(posedge clk); #1;
    model_reset();
    rst_n = 1'b1;
    load_a_slot(16'h2123, 32'h9ABCDEF1);
    for (int k = 0; k < 9; k++) begin
      step(1'b1);
      n_vec++;
      if (bus.o_A_PIXEL !== m_a_pix) begin n_err++; $display("FAIL midrst_resume k=%0d got %h want %h", k, bus.o_A_PIXEL, m_a_pix); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 800; k++) begin
      bus.i_VRAMDATA    = 16'($urandom);
      bus.i_VRAMDATA_HI = 3'($urandom);
      bus.i_CHARDATA    = $urandom;
      bus.i_SHIFTA1_n   = ($urandom_range(0, 4) != 0);
      bus.i_SHIFTA2_n   = ($urandom_range(0, 4) != 0);
      bus.i_SHIFTB_n    = ($urandom_range(0, 4) != 0);
      step($urandom_range(0, 3) != 0);
      n_vec += 5;
      if (bus.o_A_PIXEL !== m_a_pix)  begin n_err++; $display("FAIL rnd_a_pix k=%0d got %h want %h", k, bus.o_A_PIXEL, m_a_pix); end
      if (bus.o_B_PIXEL !== m_b_pix)  begin n_err++; $display("FAIL rnd_b_pix k=%0d got %h want %h", k, bus.o_B_PIXEL, m_b_pix); end
      if (bus.o_A_PAL !== m_a_opal)   begin n_err++; $display("FAIL rnd_a_pal k=%0d got %h want %h", k, bus.o_A_PAL, m_a_opal); end
      if (bus.o_B_PAL !== m_b_opal)   begin n_err++; $display("FAIL rnd_b_pal k=%0d got %h want %h", k, bus.o_B_PAL, m_b_opal); end
      if (bus.o_TILECODE !== m_tile)  begin n_err++; $display("FAIL rnd_tile k=%0d got %h want %h", k, bus.o_TILECODE, m_tile); end
`ifdef K005292_TILE_SHIFTER_MIX_EN
      n_vec += 2;
      if (bus.o_MIX_PIXEL !== m_mix_pix) begin n_err++; $display("FAIL rnd_mix_pix k=%0d got %h want %h", k, bus.o_MIX_PIXEL, m_mix_pix); end
      if (bus.o_MIX_PAL !== m_mix_pal)   begin n_err++; $display("FAIL rnd_mix_pal k=%0d got %h want %h", k, bus.o_MIX_PAL, m_mix_pal); end
`endif
    end
    set_idle();
  endtask

`ifdef K005292_TILE_SHIFTER_MIX_EN
  task automatic test_mix();
    logic [PIX_W-1:0] exp_a[3];
    logic [PIX_W-1:0] exp_mix[3];
    exp_a[0] = 4'd0; exp_a[1] = 4'd3; exp_a[2] = 4'd0;
    exp_mix[0] = 4'd5; exp_mix[1] = 4'd3; exp_mix[2] = 4'd5;
    do_reset();
    bus.i_VRAMDATA = 16'h2123;
    for (int k = 0; k < 8; k++) begin
      bus.i_CHARDATA  = (m_p == 3'd1) ? 32'h55555555 : 32'h03000000;
      bus.i_SHIFTA1_n = (m_p == 3'd7) ? 1'b0 : 1'b1;
      bus.i_SHIFTB_n  = (m_p == 3'd7) ? 1'b0 : 1'b1;
      step(1'b1);
    end
    set_idle();
    for (int k = 1; k <= 4; k++) begin
      step(1'b1);
      if (k <= 3) begin
        n_vec += 2;
        if (bus.o_A_PIXEL !== exp_a[k-1]) begin n_err++; $display("FAIL mix_a_pix k=%0d got %h want %h", k, bus.o_A_PIXEL, exp_a[k-1]); end
        if (bus.o_B_PIXEL !== 4'd5)       begin n_err++; $display("FAIL mix_b_pix k=%0d got %h want 5", k, bus.o_B_PIXEL); end
      end
      if (k >= 2) begin
        n_vec += 2;
        if (bus.o_MIX_PIXEL !== exp_mix[k-2]) begin n_err++; $display("FAIL mix_pix k=%0d got %h want %h", k, bus.o_MIX_PIXEL, exp_mix[k-2]); end
        if (bus.o_MIX_PAL !== m_mix_pal)      begin n_err++; $display("FAIL mix_pal k=%0d got %h want %h", k, bus.o_MIX_PAL, m_mix_pal); end
      end
    end
  endtask
`endif

  initial begin
    set_idle();
    bus.i_EMU_CLK6MPCEN_n = 1'b1;
    bus.i_ABS_4H = 1'b0; bus.i_ABS_2H = 1'b0; bus.i_ABS_1H = 1'b0;
    bus.i_VRAMDATA = '0; bus.i_VRAMDATA_HI = '0; bus.i_CHARDATA = '0;
    model_reset();
    #1;
    test_reset();
    test_shift(1'b0);
    test_shift(1'b1);
    test_pal_split();
    test_enable_hold();
    test_reset_midline();
`ifdef K005292_TILE_SHIFTER_MIX_EN
    test_mix();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
